key_seq_unlock: RTL and testbench

- Parametrised serial key-sequence decoder that gates the controller's memory-access path.
- Samples one key bit per VALID_CMD-qualified clock, compares against a programmable KEY, then collects MODE_W mode bits.
- On a full match, raises ACTIVE with the captured MODE.
- Counts wrong entries and enters a timed lockout after MAX_FAIL consecutive failures; downstream read/write control consumes ACTIVE/MODE.

---
 rtl/key_seq_unlock_if.sv | 16 +
 rtl/key_seq_unlock.sv | 124 ++++++++++++
 tb/tb_key_seq_unlock.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/key_seq_unlock_if.sv
// key_seq_unlock_if: key entry command inputs and unlock status outputs
interface key_seq_unlock_if #(
  parameter int MODE_W   = 1,
  parameter int MAX_FAIL = 3
);
  localparam int FW = $clog2(MAX_FAIL + 1);
  logic              INPUT_KEY;
  logic              VALID_CMD;
  logic              CLEAR;
  logic              ACTIVE;
  logic [MODE_W-1:0] MODE;
  logic              LOCKED;
  logic [FW-1:0]     FAIL_CNT;
  modport master (output INPUT_KEY, VALID_CMD, CLEAR, input ACTIVE, MODE, LOCKED, FAIL_CNT);
  modport slave  (input INPUT_KEY, VALID_CMD, CLEAR, output ACTIVE, MODE, LOCKED, FAIL_CNT);
endinterface

// File: rtl/key_seq_unlock.sv
// key_seq_unlock: serial key sequence decoder with mode capture and timed lockout
module key_seq_unlock #(
  parameter int                  KEY_LEN     = 4,
  parameter logic [KEY_LEN-1:0]  KEY         = 4'b1010,
  parameter int                  MODE_W      = 1,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  LOCK_CYCLES = 16
) (
  input logic             CLK,
  input logic             RESET,
  key_seq_unlock_if.slave bus
);
  localparam int IW = $clog2((KEY_LEN > MODE_W ? KEY_LEN : MODE_W) + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] KEY_CHK = 3'd1;
  localparam logic [2:0] MODE_IN = 3'd2;
  localparam logic [2:0] ACT     = 3'd3;
  localparam logic [2:0] LOCKOUT = 3'd4;
  logic [2:0]        state, n_state;
  logic [IW-1:0]     idx, n_idx;
  logic [MODE_W-1:0] mreg, n_mreg, mode, n_mode, shifted;
  logic [TW-1:0]     timer, n_timer;
  logic [FW-1:0]     fail, n_fail;
  logic              active, n_active, locked, n_locked, key_bit;
  // expected key bit for the current index, most significant key bit first
  always_comb begin
    key_bit = 1'b0;
    for (int i = 0; i < KEY_LEN; i++)
      if (idx == IW'(i)) key_bit = KEY[KEY_LEN-1-i];
  end
  // next-state decode; outputs are registered straight from these values
  always_comb begin
    n_state  = state;
    n_idx    = idx;
    n_mreg   = mreg;
    n_mode   = mode;
    n_timer  = timer;
    n_fail   = fail;
    n_active = active;
    n_locked = locked;
    shifted  = MODE_W'({mreg, bus.INPUT_KEY});
    case (state)
      IDLE, KEY_CHK: begin
        if (bus.CLEAR) begin
          n_state = IDLE;
          n_idx   = '0;
          n_mreg  = '0;
        end else if (bus.VALID_CMD) begin
          if (bus.INPUT_KEY == key_bit) begin
            n_state = (idx == IW'(KEY_LEN - 1)) ? MODE_IN : KEY_CHK;
            n_idx   = (idx == IW'(KEY_LEN - 1)) ? '0 : idx + IW'(1);
          end else begin
            n_idx    = '0;
            n_fail   = fail + FW'(1);
            n_state  = (fail + FW'(1) == FW'(MAX_FAIL)) ? LOCKOUT : IDLE;
            n_locked = (fail + FW'(1) == FW'(MAX_FAIL));
            n_timer  = (fail + FW'(1) == FW'(MAX_FAIL)) ? TW'(LOCK_CYCLES - 1) : timer;
          end
        end
      end
      MODE_IN: begin
        if (bus.CLEAR) begin
          n_state = IDLE;
          n_idx   = '0;
          n_mreg  = '0;
        end else if (bus.VALID_CMD) begin
          n_mreg = shifted;
          if (idx == IW'(MODE_W - 1)) begin
            n_state  = ACT;
            n_idx    = '0;
            n_active = 1'b1;
            n_mode   = shifted;
            n_fail   = '0;
          end else begin
            n_idx = idx + IW'(1);
          end
        end
      end
      ACT: begin
        if (bus.CLEAR) begin
          n_state  = IDLE;
          n_active = 1'b0;
          n_mode   = '0;
          n_mreg   = '0;
        end
      end
      LOCKOUT: begin
        n_state  = (timer == '0) ? IDLE : LOCKOUT;
        n_locked = (timer != '0);
        n_fail   = (timer == '0) ? '0 : fail;
        n_timer  = (timer == '0) ? timer : timer - TW'(1);
      end
      default: n_state = IDLE;
    endcase
  end
  // state and output registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      idx    <= '0;
      mreg   <= '0;
      mode   <= '0;
      timer  <= '0;
      fail   <= '0;
      active <= 1'b0;
      locked <= 1'b0;
    end else begin
      state  <= n_state;
      idx    <= n_idx;
      mreg   <= n_mreg;
      mode   <= n_mode;
      timer  <= n_timer;
      fail   <= n_fail;
      active <= n_active;
      locked <= n_locked;
    end
  end
  assign bus.ACTIVE   = active;
  assign bus.MODE     = mode;
  assign bus.LOCKED   = locked;
  assign bus.FAIL_CNT = fail;
endmodule

// File: tb/tb_key_seq_unlock.sv
// tb_key_seq_unlock: directed vector and corner-sequence checks for key_seq_unlock
module tb_key_seq_unlock;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 CLK = ~CLK;
  key_seq_unlock_if #(.MODE_W(1), .MAX_FAIL(3)) ia ();
  key_seq_unlock_if #(.MODE_W(2), .MAX_FAIL(3)) ib ();
  key_seq_unlock dut_a (.CLK(CLK), .RESET(RESET), .bus(ia.slave));
  key_seq_unlock #(.KEY_LEN(6), .KEY(6'b110010), .MODE_W(2), .MAX_FAIL(3), .LOCK_CYCLES(16))
    dut_b (.CLK(CLK), .RESET(RESET), .bus(ib.slave));
  typedef struct packed {
    logic       v;
    logic       k;
    logic       c;
    logic       ea;
    logic       em;
    logic       el;
    logic [1:0] ef;
  } vec_t;
  vec_t vecs[18];
  task automatic drive(input logic v, input logic k, input logic c);
    ia.VALID_CMD = v; ia.INPUT_KEY = k; ia.CLEAR = c;
    ib.VALID_CMD = v; ib.INPUT_KEY = k; ib.CLEAR = c;
  endtask
  task automatic step(input logic v, input logic k, input logic c);
    @(negedge CLK);
    drive(v, k, c);
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask
  task automatic chk_a(input string nm, input logic [4:0] exp);
    logic [4:0] got;
    got = {ia.ACTIVE, ia.MODE, ia.LOCKED, ia.FAIL_CNT};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s {active,mode,locked,fail_cnt} got=%b expected=%b", nm, got, exp);
    end
  endtask
  task automatic chk_b(input string nm, input logic [5:0] exp);
    logic [5:0] got;
    got = {ib.ACTIVE, ib.MODE, ib.LOCKED, ib.FAIL_CNT};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s {active,mode[1:0],locked,fail_cnt} got=%b expected=%b", nm, got, exp);
    end
  endtask
  task automatic enter_a(input logic [4:0] bits);
    for (int i = 4; i >= 0; i--) step(1'b1, bits[i], 1'b0);
  endtask
  initial begin
    int n;
    logic [4:0] sb;
    logic [5:0] kb;
    vecs[0]  = 8'b110_000_00;
    vecs[1]  = 8'b100_000_00;
    vecs[2]  = 8'b010_000_00;
    vecs[3]  = 8'b110_000_00;
    vecs[4]  = 8'b100_000_00;
    vecs[5]  = 8'b100_100_00;
    vecs[6]  = 8'b110_100_00;
    vecs[7]  = 8'b001_000_00;
    vecs[8]  = 8'b110_000_00;
    vecs[9]  = 8'b110_000_01;
    vecs[10] = 8'b110_000_01;
    vecs[11] = 8'b001_000_01;
    vecs[12] = 8'b110_000_01;
    vecs[13] = 8'b100_000_01;
    vecs[14] = 8'b110_000_01;
    vecs[15] = 8'b100_000_01;
    vecs[16] = 8'b110_110_00;
    vecs[17] = 8'b001_000_00;
    do_reset();
    chk_a("reset_a", 5'b0_0_0_00);
    chk_b("reset_b", 6'b0_00_0_00);
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].v, vecs[i].k, vecs[i].c);
      chk_a($sformatf("vec%0d", i), {vecs[i].ea, vecs[i].em, vecs[i].el, vecs[i].ef});
    end
    enter_a(5'b10101);
    chk_a("unlock_mode1", 5'b1_1_0_00);
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      chk_a($sformatf("hold%0d", i), 5'b1_1_0_00);
    end
    step(1'b0, 1'b0, 1'b1);
    chk_a("clear_act", 5'b0_0_0_00);
    step(1'b1, 1'b0, 1'b0);
    chk_a("lock_fail1", 5'b0_0_0_01);
    step(1'b1, 1'b0, 1'b0);
    chk_a("lock_fail2", 5'b0_0_0_10);
    step(1'b1, 1'b0, 1'b0);
    chk_a("lock_enter", 5'b0_0_1_11);
    n = 1;
    sb = 5'b10101;
    for (int i = 0; i < 40; i++) begin
      step(i < 5, (i < 5) ? sb[4-i] : 1'b0, i == 2);
      if (i == 5) chk_a("lock_ignores_key", 5'b0_0_1_11);
      if (!ia.LOCKED) break;
      n++;
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL lock_len got=%0d expected=16", n);
    end
    chk_a("lock_release", 5'b0_0_0_00);
    enter_a(5'b10100);
    chk_a("unlock_after_lock", 5'b1_0_0_00);
    step(1'b0, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    chk_b("b_fail1", 6'b0_00_0_01);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk_b("b_clear_mid_key", 6'b0_00_0_01);
    kb = 6'b110010;
    for (int i = 5; i >= 0; i--) begin
      step(1'b1, kb[i], 1'b0);
      step(1'b0, ~kb[i], 1'b0);
    end
    chk_b("b_key_done", 6'b0_00_0_01);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_b("b_mode_half", 6'b0_00_0_01);
    step(1'b1, 1'b0, 1'b0);
    chk_b("b_unlock", 6'b1_10_0_00);
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    enter_a(5'b10101);
    chk_a("pre_mode_rst", 5'b1_1_0_00);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, sb[4-i], 1'b0);
    chk_a("mid_mode_in", 5'b0_0_0_01);
    #2 RESET = 1'b1;
    #1 chk_a("async_rst_mode", 5'b0_0_0_00);
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_a("pre_lock_rst", 5'b0_0_1_11);
    #2 RESET = 1'b1;
    #1 chk_a("async_rst_lock", 5'b0_0_0_00);
    @(negedge CLK);
    RESET = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk_a("no_lock_after_rst", 5'b0_0_0_00);
    enter_a(5'b10101);
    chk_a("unlock_after_rst", 5'b1_1_0_00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
